// File: rtl/cond_flag_unit.sv
`default_nettype none
// ============================================================================
// Module      : cond_flag_unit
// Description : Conditional-execution and status-flag stage. Holds the
//               architectural NZCV register, evaluates the instruction
//               condition field at decode, gates the control unit's raw write
//               enables and keeps executed/skipped instruction counters.
// Ports       : clk, RESET           - clock, synchronous active-high reset
//               alu_flags[3:0]       - live ALU flags {N,Z,C,V}
//               cond[3:0]            - instruction condition field
//               decode_strobe        - latch condition result this cycle
//               flag_w[1:0]          - raw flag writes (bit1 N/Z, bit0 C/V)
//               pc_s, pc_update      - raw / unconditional PC write requests
//               reg_w, mem_w         - raw register / memory write requests
//               instr_done           - last cycle of an instruction
//               pc_write, reg_write, mem_write - gated write enables
//               ALU_flags[3:0]       - registered architectural flags
//               cond_ex              - latched condition-pass bit
//               exec_cnt, skip_cnt   - saturating debug counters
// Revision    : 1.0 - initial release
// ============================================================================
module cond_flag_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             RESET,
    input  logic [3:0]       alu_flags,
    input  logic [3:0]       cond,
    input  logic             decode_strobe,
    input  logic [1:0]       flag_w,
    input  logic             pc_s,
    input  logic             pc_update,
    input  logic             reg_w,
    input  logic             mem_w,
    input  logic             instr_done,
    output logic             pc_write,
    output logic             reg_write,
    output logic             mem_write,
    output logic [3:0]       ALU_flags,
    output logic             cond_ex,
    output logic [CNT_W-1:0] exec_cnt,
    output logic [CNT_W-1:0] skip_cnt
);

    localparam logic [CNT_W-1:0] c_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_MAX = {CNT_W{1'b1}};

    logic [3:0]       r_flags;
    logic             r_cond_ex;
    logic [CNT_W-1:0] r_exec_cnt;
    logic [CNT_W-1:0] r_skip_cnt;

    logic             w_n;
    logic             w_z;
    logic             w_c;
    logic             w_v;
    logic             w_pass;

    // Evaluation always uses the registered flags so a flag write landing on
    // the decode edge cannot influence the decision for this instruction.
    assign w_n = r_flags[3];
    assign w_z = r_flags[2];
    assign w_c = r_flags[1];
    assign w_v = r_flags[0];

    always_comb begin
        w_pass = 1'b0;
        case (cond)
            4'b0000: w_pass = w_z;
            4'b0001: w_pass = ~w_z;
            4'b0010: w_pass = w_c;
            4'b0011: w_pass = ~w_c;
            4'b0100: w_pass = w_n;
            4'b0101: w_pass = ~w_n;
            4'b0110: w_pass = w_v;
            4'b0111: w_pass = ~w_v;
            4'b1000: w_pass = w_c & ~w_z;
            4'b1001: w_pass = ~w_c | w_z;
            4'b1010: w_pass = (w_n == w_v);
            4'b1011: w_pass = (w_n != w_v);
            4'b1100: w_pass = ~w_z & (w_n == w_v);
            4'b1101: w_pass = w_z | (w_n != w_v);
            4'b1110: w_pass = 1'b1;
            default: w_pass = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            r_flags    <= 4'b0000;
            r_cond_ex  <= 1'b0;
            r_exec_cnt <= '0;
            r_skip_cnt <= '0;
        end else begin
            // Counting sees the outgoing instruction's cond_ex even when the
            // next decode reloads it on this same edge.
            if (instr_done) begin
                if (r_cond_ex) begin
                    if (r_exec_cnt != c_MAX) begin
                        r_exec_cnt <= r_exec_cnt + c_ONE;
                    end
                end else begin
                    if (r_skip_cnt != c_MAX) begin
                        r_skip_cnt <= r_skip_cnt + c_ONE;
                    end
                end
            end
            if (decode_strobe) begin
                r_cond_ex <= w_pass;
            end
            if (flag_w[1] && r_cond_ex) begin
                r_flags[3:2] <= alu_flags[3:2];
            end
            if (flag_w[0] && r_cond_ex) begin
                r_flags[1:0] <= alu_flags[1:0];
            end
        end
    end

    // Gated enables are combinational with no added latency; reset blocks all
    // of them, including the unconditional fetch increment.
    assign pc_write  = ~RESET & (pc_update | (pc_s & r_cond_ex));
    assign reg_write = ~RESET & reg_w & r_cond_ex;
    assign mem_write = ~RESET & mem_w & r_cond_ex;

    assign ALU_flags = r_flags;
    assign cond_ex   = r_cond_ex;
    assign exec_cnt  = r_exec_cnt;
    assign skip_cnt  = r_skip_cnt;

endmodule
`default_nettype wire

// File: tb/tb_cond_flag_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_cond_flag_unit
// Description : Scoreboard bench for cond_flag_unit. A default-width instance
//               and a CNT_W=2 instance share the same stimulus; expected
//               values are queued when stimulus is driven and compared when
//               the outputs are sampled.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cond_flag_unit;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    logic        clk;
    logic        RESET;
    logic [3:0]  alu_flags;
    logic [3:0]  cond;
    logic        decode_strobe;
    logic [1:0]  flag_w;
    logic        pc_s;
    logic        pc_update;
    logic        reg_w;
    logic        mem_w;
    logic        instr_done;

    logic        pc_write, reg_write, mem_write, cond_ex;
    logic [3:0]  ALU_flags;
    logic [15:0] exec_cnt, skip_cnt;

    logic        s_pc_write, s_reg_write, s_mem_write, s_cond_ex;
    logic [3:0]  s_ALU_flags;
    logic [1:0]  s_exec_cnt, s_skip_cnt;

    int          r_checks;
    int          r_errors;
    exp_t        r_q[$];

    // Reference state
    logic [3:0]  m_flags;
    logic        m_cex;
    logic [15:0] m_exec, m_skip;
    logic [1:0]  m2_exec, m2_skip;

    cond_flag_unit #(.CNT_W(16)) u_dut (
        .clk(clk), .RESET(RESET), .alu_flags(alu_flags), .cond(cond),
        .decode_strobe(decode_strobe), .flag_w(flag_w), .pc_s(pc_s),
        .pc_update(pc_update), .reg_w(reg_w), .mem_w(mem_w),
        .instr_done(instr_done), .pc_write(pc_write), .reg_write(reg_write),
        .mem_write(mem_write), .ALU_flags(ALU_flags), .cond_ex(cond_ex),
        .exec_cnt(exec_cnt), .skip_cnt(skip_cnt)
    );

    cond_flag_unit #(.CNT_W(2)) u_dut_small (
        .clk(clk), .RESET(RESET), .alu_flags(alu_flags), .cond(cond),
        .decode_strobe(decode_strobe), .flag_w(flag_w), .pc_s(pc_s),
        .pc_update(pc_update), .reg_w(reg_w), .mem_w(mem_w),
        .instr_done(instr_done), .pc_write(s_pc_write), .reg_write(s_reg_write),
        .mem_write(s_mem_write), .ALU_flags(s_ALU_flags), .cond_ex(s_cond_ex),
        .exec_cnt(s_exec_cnt), .skip_cnt(s_skip_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        r_checks = r_checks + 1;
        if (got !== exp) begin
            r_errors = r_errors + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic cond_ref(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cy;
            4'h3: return !cy;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cy && !z;
            4'h9: return !cy || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] pop_exp(output string tag);
        exp_t e;
        e = r_q.pop_front();
        tag = e.tag;
        return e.exp;
    endfunction

    // One clock cycle: drive at negedge, queue expectations, compare the
    // combinational enables before the edge and the state after it.
    task automatic cyc(input logic rst, input logic [3:0] c, input logic ds,
                       input logic [1:0] fw, input logic [3:0] af, input logic pcs,
                       input logic pcu, input logic rw, input logic mw, input logic dn);
        logic [3:0]  n_flags;
        logic        n_cex;
        logic [15:0] n_exec, n_skip;
        logic [1:0]  n2_exec, n2_skip;
        string       t;
        logic [31:0] e;

        RESET = rst; cond = c; decode_strobe = ds; flag_w = fw; alu_flags = af;
        pc_s = pcs; pc_update = pcu; reg_w = rw; mem_w = mw; instr_done = dn;

        r_q.push_back('{"pc_write",  {31'd0, !rst && (pcu || (pcs && m_cex))}});
        r_q.push_back('{"reg_write", {31'd0, !rst && rw && m_cex}});
        r_q.push_back('{"mem_write", {31'd0, !rst && mw && m_cex}});

        n_flags = m_flags; n_cex = m_cex;
        n_exec = m_exec; n_skip = m_skip; n2_exec = m2_exec; n2_skip = m2_skip;
        if (rst) begin
            n_flags = 4'h0; n_cex = 1'b0;
            n_exec = '0; n_skip = '0; n2_exec = '0; n2_skip = '0;
        end else begin
            if (dn && m_cex) begin
                if (m_exec != 16'hFFFF) n_exec = m_exec + 16'd1;
                if (m2_exec != 2'b11)   n2_exec = m2_exec + 2'd1;
            end else if (dn) begin
                if (m_skip != 16'hFFFF) n_skip = m_skip + 16'd1;
                if (m2_skip != 2'b11)   n2_skip = m2_skip + 2'd1;
            end
            if (ds) n_cex = cond_ref(c, m_flags);
            if (fw[1] && m_cex) n_flags[3:2] = af[3:2];
            if (fw[0] && m_cex) n_flags[1:0] = af[1:0];
        end
        r_q.push_back('{"ALU_flags", {28'd0, n_flags}});
        r_q.push_back('{"cond_ex",   {31'd0, n_cex}});
        r_q.push_back('{"exec_cnt",  {16'd0, n_exec}});
        r_q.push_back('{"skip_cnt",  {16'd0, n_skip}});
        r_q.push_back('{"exec_sat",  {30'd0, n2_exec}});
        r_q.push_back('{"skip_sat",  {30'd0, n2_skip}});

        #2;
        e = pop_exp(t); chk(t, {31'd0, pc_write}, e);
        e = pop_exp(t); chk(t, {31'd0, reg_write}, e);
        e = pop_exp(t); chk(t, {31'd0, mem_write}, e);

        @(posedge clk);
        #1;
        m_flags = n_flags; m_cex = n_cex;
        m_exec = n_exec; m_skip = n_skip; m2_exec = n2_exec; m2_skip = n2_skip;
        e = pop_exp(t); chk(t, {28'd0, ALU_flags}, e);
        e = pop_exp(t); chk(t, {31'd0, cond_ex}, e);
        e = pop_exp(t); chk(t, {16'd0, exec_cnt}, e);
        e = pop_exp(t); chk(t, {16'd0, skip_cnt}, e);
        e = pop_exp(t); chk(t, {30'd0, s_exec_cnt}, e);
        e = pop_exp(t); chk(t, {30'd0, s_skip_cnt}, e);
        @(negedge clk);
    endtask

    // Full instruction: fetch, decode, execute with writes, done.
    task automatic instr(input logic [3:0] c, input logic [1:0] fw, input logic [3:0] af,
                         input logic pcs, input logic rw, input logic mw);
        cyc(0, 4'h0, 0, 2'b00, 4'h0, 0, 1, 0, 0, 0);
        cyc(0, c,    1, 2'b00, 4'h0, 0, 0, 0, 0, 0);
        cyc(0, c,    0, fw,    af,   pcs, 0, rw, mw, 0);
        cyc(0, c,    0, 2'b00, 4'h0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        r_checks = 0; r_errors = 0;
        m_flags = '0; m_cex = 0; m_exec = '0; m_skip = '0; m2_exec = '0; m2_skip = '0;
        RESET = 1; cond = 0; decode_strobe = 0; flag_w = 0; alu_flags = 0;
        pc_s = 0; pc_update = 0; reg_w = 0; mem_w = 0; instr_done = 0;
        @(negedge clk);

        // Reset, then AL with register and full flag write
        cyc(1, 4'h0, 0, 2'b00, 4'h0, 0, 1, 1, 1, 0);
        instr(4'hE, 2'b11, 4'b0100, 0, 1, 0);
        // EQ pass (Z=1), then clear flags, EQ fail with branch
        instr(4'h0, 2'b11, 4'b0000, 1, 0, 0);
        instr(4'h0, 2'b11, 4'b1111, 1, 1, 1);
        // Signed conditions with N=1,V=1
        instr(4'hE, 2'b11, 4'b1001, 0, 0, 0);
        instr(4'hA, 2'b00, 4'h0, 1, 1, 0);
        instr(4'hC, 2'b00, 4'h0, 0, 0, 1);
        instr(4'hB, 2'b00, 4'h0, 1, 1, 1);
        instr(4'hD, 2'b00, 4'h0, 1, 1, 1);
        instr(4'hF, 2'b00, 4'h0, 1, 1, 1);
        // N=1,V=0: GE fails, LT passes
        instr(4'hE, 2'b11, 4'b1000, 0, 0, 0);
        instr(4'hA, 2'b00, 4'h0, 1, 0, 0);
        instr(4'hB, 2'b00, 4'h0, 1, 0, 0);
        // Partial flag writes: clear, write N/Z only, then attempt under fail
        instr(4'hE, 2'b11, 4'b0000, 0, 0, 0);
        instr(4'hE, 2'b10, 4'b1111, 0, 0, 0);
        instr(4'hF, 2'b11, 4'b0011, 0, 0, 0);
        instr(4'hE, 2'b01, 4'b0010, 0, 0, 0);
        // Decode with simultaneous flag write and instr_done (old cond_ex counted)
        cyc(0, 4'hF, 1, 2'b00, 4'h0, 0, 0, 0, 0, 1);
        cyc(0, 4'hE, 1, 2'b11, 4'b0101, 0, 0, 0, 0, 1);
        cyc(0, 4'h0, 1, 2'b11, 4'b0000, 0, 0, 0, 0, 1);
        // Mid-instruction reset while mem_w active and cond_ex=1
        cyc(0, 4'hE, 1, 2'b00, 4'h0, 0, 0, 0, 0, 0);
        cyc(1, 4'hE, 0, 2'b11, 4'hF, 1, 0, 1, 1, 1);
        cyc(0, 4'h0, 0, 2'b00, 4'h0, 0, 1, 0, 0, 0);
        // Randomised traffic
        for (int i = 0; i < 300; i++) begin
            cyc(($urandom_range(0, 49) == 0), 4'($urandom), 1'($urandom),
                2'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
                1'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", r_errors, r_checks);
        $finish;
    end

endmodule
`default_nettype wire
